// File: rtl/div_unit_if.sv
// div_unit_if: EX-stage request/response bundle for the multi-cycle divider.
// master = EX stage (drives operands and control), slave = div_unit.
interface div_unit_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );

endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
// result_o = {remainder, quotient}; ready_o is held while start_i stays high.
// Optional macro DIV_EARLY_OUT_EN: skip the iteration when |divisor| > |dividend|.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    div_unit_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign1_q, sign1_d;
    logic               sign2_q, sign2_d;
    logic               signed_q, signed_d;
    logic               ready_q, ready_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   mag1_c, mag2_c;
    logic [WIDTH:0]     shifted_c, trial_c;
    logic [WIDTH-1:0]   quo_fix_c, rem_fix_c;
    logic               neg_quo_c, neg_rem_c;

    // Operand magnitudes; the most negative value keeps its unsigned magnitude.
    assign mag1_c = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ?
                    ((~bus.opdata1_i) + ONE_W) : bus.opdata1_i;
    assign mag2_c = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ?
                    ((~bus.opdata2_i) + ONE_W) : bus.opdata2_i;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    assign shifted_c = {rem_q, quo_q[WIDTH-1]};
    assign trial_c   = shifted_c - {1'b0, dvs_q};

    // Sign post-correction applied when the result is presented.
    assign neg_quo_c = signed_q & (sign1_q ^ sign2_q);
    assign neg_rem_c = signed_q & sign1_q;
    assign quo_fix_c = neg_quo_c ? ((~quo_q) + ONE_W) : quo_q;
    assign rem_fix_c = neg_rem_c ? ((~rem_q) + ONE_W) : rem_q;

    // Next-state, datapath and output decode.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        signed_d = signed_q;
        ready_d  = 1'b0;
        result_d = '0;

        case (state_q)
            S_FREE: begin
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (mag2_c > mag1_c) begin
                        // Quotient is zero and the dividend is the remainder as-is.
                        state_d  = S_END;
                        rem_d    = bus.opdata1_i;
                        quo_d    = '0;
                        sign1_d  = 1'b0;
                        sign2_d  = 1'b0;
                        signed_d = 1'b0;
                    end
`endif
                    else begin
                        state_d  = S_ON;
                        rem_d    = '0;
                        quo_d    = mag1_c;
                        dvs_d    = mag2_c;
                        cnt_d    = '0;
                        sign1_d  = bus.opdata1_i[WIDTH-1];
                        sign2_d  = bus.opdata2_i[WIDTH-1];
                        signed_d = bus.signed_div_i;
                    end
                end
            end

            S_BYZERO: begin
                if (bus.annul_i) begin
                    state_d = S_FREE;
                end else begin
                    state_d  = S_END;
                    rem_d    = '0;
                    quo_d    = '0;
                    signed_d = 1'b0;
                end
            end

            S_ON: begin
                if (bus.annul_i) begin
                    state_d = S_FREE;
                end else if (cnt_q != CNT_W'(WIDTH)) begin
                    if (!trial_c[WIDTH]) begin
                        rem_d = trial_c[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted_c[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(WIDTH)) begin
                        state_d = S_END;
                    end
                end else begin
                    state_d = S_END;
                end
            end

            S_END: begin
                if (bus.annul_i) begin
                    state_d = S_FREE;
                end else if (bus.start_i) begin
                    ready_d  = 1'b1;
                    result_d = {rem_fix_c, quo_fix_c};
                end else begin
                    state_d = S_FREE;
                end
            end

            default: begin
                state_d = S_FREE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FREE;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            signed_q <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            signed_q <= signed_d;
            ready_q  <= ready_d;
            result_q <= result_d;
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against an
// arithmetic reference model (SV integer division on 64-bit values).
module tb_div_unit;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;

    // Single comparison point.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result: truncating division, remainder takes dividend sign, x/0 = 0.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Reference latency: edges from start sample to first ready_o.
    function automatic int ref_lat(input logic sgn, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        longint ma, mb;
`endif
        if (b == 32'h0) return 2;
`ifdef DIV_EARLY_OUT_EN
        ma = sgn ? ((longint'($signed(a)) < 0) ? -longint'($signed(a)) : longint'($signed(a)))
                 : longint'({32'h0, a});
        mb = sgn ? ((longint'($signed(b)) < 0) ? -longint'($signed(b)) : longint'($signed(b)))
                 : longint'({32'h0, b});
        if (mb > ma) return 1;
`endif
        return 33;
    endfunction

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
    endtask

    // Wait (bounded) for ready_o; lat = edge index after which it was seen, -1 on timeout.
    task automatic wait_ready(input bit scramble, output int lat);
        int  edges;
        bit  seen;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 60) begin
            @(posedge clk); #1;
            edges++;
            if (bus.ready_o === 1'b1) begin
                seen = 1'b1;
            end else if (scramble && edges == 3) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~bus.signed_div_i;
            end
        end
        lat = seen ? edges - 1 : -1;
    endtask

    // Full transaction: latency, result, hold while start high, clear after start drops.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit scramble);
        logic [63:0] exp_res;
        int          lat;
        exp_res = ref_div(sgn, a, b);
        issue(sgn, a, b);
        wait_ready(scramble, lat);
        check({tag, ".lat"}, 64'(lat), 64'(ref_lat(sgn, a, b)));
        check({tag, ".res"}, bus.result_o, exp_res);
        @(posedge clk); #1;
        check({tag, ".hold_rdy"}, 64'(bus.ready_o), 64'h1);
        check({tag, ".hold_res"}, bus.result_o, exp_res);
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        check({tag, ".clr_rdy"}, 64'(bus.ready_o), 64'h0);
        check({tag, ".clr_res"}, bus.result_o, 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          rises;
        int          lat;
        logic [31:0] ra, rb;
        logic        rs;

        rst              = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset.rdy", 64'(bus.ready_o), 64'h0);
        check("reset.res", bus.result_o, 64'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle.rdy", 64'(bus.ready_o), 64'h0);
        check("idle.res", bus.result_o, 64'h0);

        // Directed cases.
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        check("divu_100_7.const", ref_div(1'b0, 32'd100, 32'd7), {32'h2, 32'hE});
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, 1'b0);
        run_op("div_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE, 1'b0);
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 1'b0);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_3_10", 1'b0, 32'd3, 32'd10, 1'b0);
        run_op("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, 1'b0);
        run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);

        // Annul dominates start in FREE, then aborts an in-flight division.
        rises = 0;
        issue(1'b0, 32'd1000, 32'd3);
        bus.annul_i = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.ready_o !== 1'b0) rises++;
        end
        bus.annul_i = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.ready_o !== 1'b0) rises++;
        end
        bus.annul_i = 1'b1;
        @(posedge clk); #1;
        if (bus.ready_o !== 1'b0) rises++;
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        if (bus.ready_o !== 1'b0) rises++;
        check("annul.no_ready", 64'(rises), 64'h0);
        check("annul.res", bus.result_o, 64'h0);
        run_op("after_annul_9_4", 1'b0, 32'd9, 32'd4, 1'b0);

        // Annul while presenting a result.
        issue(1'b0, 32'd100, 32'd7);
        wait_ready(1'b0, lat);
        check("annul_end.pre", bus.result_o, {32'h2, 32'hE});
        bus.annul_i = 1'b1;
        @(posedge clk); #1;
        check("annul_end.rdy", 64'(bus.ready_o), 64'h0);
        check("annul_end.res", bus.result_o, 64'h0);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset mid-division, between edges.
        issue(1'b0, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_on.rdy", 64'(bus.ready_o), 64'h0);
        check("rst_on.res", bus.result_o, 64'h0);
        bus.start_i = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst_15_4", 1'b0, 32'd15, 32'd4, 1'b0);

        // Asynchronous reset while a result is held.
        issue(1'b0, 32'd100, 32'd7);
        wait_ready(1'b0, lat);
        check("rst_end.pre_rdy", 64'(bus.ready_o), 64'h1);
        #3;
        rst = 1'b0;
        #1;
        check("rst_end.rdy", 64'(bus.ready_o), 64'h0);
        check("rst_end.res", bus.result_o, 64'h0);
        bus.start_i = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;

        // Randomized operations; operands are scrambled while busy.
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       rb = 32'h0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       ra = 32'h8000_0000;
                1:       ra = $urandom_range(0, 20);
                default: ra = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), rs, ra, rb, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
